mem_ctrl: RTL and testbench

Memory controller. It serializes 32-bit load, store and instruction-fetch requests onto the byte-wide single-port RAM/IO bus. It sits between the store/load buffer (SLB) and instruction fetch on one side, and the external RAM on the other. It is the responder to the SLB's load/store request pulses: it returns raw zero-filled bytes, and the SLB performs sign/zero extension.

---
 rtl/mem_ctrl.sv | 290 +++++++++++++++++++++++++++++
 tb/tb_mem_ctrl.sv | 398 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_ctrl.sv
// -----------------------------------------------------------------------------
// mem_ctrl
//
// Serializes 32-bit load, store and instruction-fetch requests onto the
// byte-wide single-port RAM/IO bus. Loads return raw zero-filled bytes; the
// SLB does any sign/zero extension itself.
//
// Ports
//   clk, rst, rdy                  clock, sync active-high reset, global enable
//   Clear_flag                     pipeline flush
//   SLB_to_memctrl_needchange      load request pulse
//   SLB_to_memctrl_needchange2     store request pulse
//   SLB_to_memctrl_ordertype       access type code
//   SLB_to_memctrl_vj / _A         base / offset, address = vj + A
//   SLB_to_memctrl_vk              store data, little-endian
//   memctrl_data_ok / _data_ans    one-cycle completion pulse + load bytes
//   if_req / if_addr               fetch request pulse + word address
//   if_data_ok / if_data           one-cycle fetch completion pulse + word
//   mem_din                        RAM read byte (valid the cycle after mem_a)
//   mem_dout / mem_a / mem_wr      write byte, byte address, write strobe
//   io_buffer_full                 IO output FIFO full
// -----------------------------------------------------------------------------
module mem_ctrl #(
    parameter int          TYPE_W  = 6,
    parameter int          T_LB    = 10,
    parameter int          T_LH    = 11,
    parameter int          T_LW    = 12,
    parameter int          T_LBU   = 13,
    parameter int          T_LHU   = 14,
    parameter int          T_SB    = 15,
    parameter int          T_SH    = 16,
    parameter int          T_SW    = 17,
    parameter logic [31:0] IO_BASE = 32'h0003_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              Clear_flag,
    input  logic              SLB_to_memctrl_needchange,
    input  logic              SLB_to_memctrl_needchange2,
    input  logic [TYPE_W-1:0] SLB_to_memctrl_ordertype,
    input  logic [31:0]       SLB_to_memctrl_vj,
    input  logic [31:0]       SLB_to_memctrl_A,
    input  logic [31:0]       SLB_to_memctrl_vk,
    output logic              memctrl_data_ok,
    output logic [31:0]       memctrl_data_ans,
    input  logic              if_req,
    input  logic [31:0]       if_addr,
    output logic              if_data_ok,
    output logic [31:0]       if_data,
    input  logic [7:0]        mem_din,
    output logic [7:0]        mem_dout,
    output logic [31:0]       mem_a,
    output logic              mem_wr,
    input  logic              io_buffer_full
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    // Byte count of an access; unknown codes fall back to a single byte.
    function automatic logic [2:0] type_len(input logic [TYPE_W-1:0] t);
        if (t == TYPE_W'(T_LB) || t == TYPE_W'(T_LBU) || t == TYPE_W'(T_SB))
            return 3'd1;
        else if (t == TYPE_W'(T_LH) || t == TYPE_W'(T_LHU) || t == TYPE_W'(T_SH))
            return 3'd2;
        else if (t == TYPE_W'(T_LW) || t == TYPE_W'(T_SW))
            return 3'd4;
        else
            return 3'd1;
    endfunction

    state_t      state_reg, state_next;

    // Active transfer
    logic [2:0]  cnt_reg, cnt_next;
    logic [2:0]  len_reg, len_next;
    logic [31:0] addr_reg, addr_next;
    logic [31:0] wdata_reg, wdata_next;
    logic [31:0] rdata_reg, rdata_next;
    logic        is_fetch_reg, is_fetch_next;
    logic        flushed_reg, flushed_next;

    // Pending data slot (load or store) and fetch slot
    logic        dslot_valid_reg, dslot_valid_next;
    logic        dslot_store_reg, dslot_store_next;
    logic [2:0]  dslot_len_reg, dslot_len_next;
    logic [31:0] dslot_addr_reg, dslot_addr_next;
    logic [31:0] dslot_data_reg, dslot_data_next;
    logic        fslot_valid_reg, fslot_valid_next;
    logic [31:0] fslot_addr_reg, fslot_addr_next;

    // Registered completion outputs
    logic        data_ok_reg, data_ok_next;
    logic [31:0] data_ans_reg, data_ans_next;
    logic        if_ok_reg, if_ok_next;
    logic [31:0] if_data_reg, if_data_next;

    logic [31:0] cur_addr;
    logic [1:0]  rd_lane;
    logic        in_io;
    logic        wr_stall;
    logic [7:0]  wr_lane [4];

    assign cur_addr = addr_reg + {29'd0, cnt_reg};
    // Byte k arrives while cnt == k+1, so it lands in lane cnt-1.
    assign rd_lane  = cnt_reg[1:0] - 2'd1;
    assign in_io    = (cur_addr >= IO_BASE) && (cur_addr <= IO_BASE + 32'd7);
    assign wr_stall = in_io && io_buffer_full;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_wr_lane
            assign wr_lane[gi] = wdata_reg[8*gi +: 8];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst)
            state_reg <= IDLE;
        else if (rdy)
            state_reg <= state_next;
    end

    always_comb begin
        state_next       = state_reg;
        cnt_next         = cnt_reg;
        len_next         = len_reg;
        addr_next        = addr_reg;
        wdata_next       = wdata_reg;
        rdata_next       = rdata_reg;
        is_fetch_next    = is_fetch_reg;
        flushed_next     = flushed_reg;
        dslot_valid_next = dslot_valid_reg;
        dslot_store_next = dslot_store_reg;
        dslot_len_next   = dslot_len_reg;
        dslot_addr_next  = dslot_addr_reg;
        dslot_data_next  = dslot_data_reg;
        fslot_valid_next = fslot_valid_reg;
        fslot_addr_next  = fslot_addr_reg;
        data_ok_next     = 1'b0;
        data_ans_next    = 32'd0;
        if_ok_next       = 1'b0;
        if_data_next     = 32'd0;
        mem_a            = 32'd0;
        mem_dout         = 8'd0;
        mem_wr           = 1'b0;

        // Requesters never repeat a pulse, so latch every one immediately.
        // A flush drops both slots and any request arriving alongside it.
        if (Clear_flag) begin
            dslot_valid_next = 1'b0;
            fslot_valid_next = 1'b0;
        end else begin
            if (SLB_to_memctrl_needchange || SLB_to_memctrl_needchange2) begin
                dslot_valid_next = 1'b1;
                dslot_store_next = SLB_to_memctrl_needchange2;
                dslot_len_next   = type_len(SLB_to_memctrl_ordertype);
                dslot_addr_next  = SLB_to_memctrl_vj + SLB_to_memctrl_A;
                dslot_data_next  = SLB_to_memctrl_vk;
            end
            if (if_req) begin
                fslot_valid_next = 1'b1;
                fslot_addr_next  = if_addr;
            end
        end

        case (state_reg)
            IDLE: begin
                // Slot next-values include a same-edge pulse, so a fresh
                // request starts without an extra capture cycle.
                if (dslot_valid_next) begin
                    dslot_valid_next = 1'b0;
                    state_next       = dslot_store_next ? WRITE : READ;
                    addr_next        = dslot_addr_next;
                    len_next         = dslot_len_next;
                    wdata_next       = dslot_data_next;
                    rdata_next       = 32'd0;
                    cnt_next         = 3'd0;
                    is_fetch_next    = 1'b0;
                    flushed_next     = 1'b0;
                end else if (fslot_valid_next) begin
                    fslot_valid_next = 1'b0;
                    state_next       = READ;
                    addr_next        = fslot_addr_next;
                    len_next         = 3'd4;
                    wdata_next       = 32'd0;
                    rdata_next       = 32'd0;
                    cnt_next         = 3'd0;
                    is_fetch_next    = 1'b1;
                    flushed_next     = 1'b0;
                end
            end

            READ: begin
                // cnt runs 0..len: addresses go out for cnt < len, the last
                // cycle only collects the trailing byte (bus left idle).
                if (cnt_reg < len_reg)
                    mem_a = cur_addr;
                if (cnt_reg != 3'd0)
                    rdata_next[{rd_lane, 3'b000} +: 8] = mem_din;
                cnt_next = cnt_reg + 3'd1;
                if (Clear_flag) begin
                    state_next = IDLE;
                end else if (cnt_reg == len_reg) begin
                    state_next = DONE;
                    if (is_fetch_reg) begin
                        if_ok_next   = 1'b1;
                        if_data_next = rdata_next;
                    end else begin
                        data_ok_next  = 1'b1;
                        data_ans_next = rdata_next;
                    end
                end
            end

            WRITE: begin
                mem_a    = cur_addr;
                mem_dout = wr_lane[cnt_reg[1:0]];
                mem_wr   = !wr_stall;
                // A store already on the bus is committed; a flush only
                // silences its completion since the SLB has been emptied.
                if (Clear_flag)
                    flushed_next = 1'b1;
                if (!wr_stall) begin
                    cnt_next = cnt_reg + 3'd1;
                    if (cnt_reg == len_reg - 3'd1) begin
                        state_next   = DONE;
                        data_ok_next = !(flushed_reg || Clear_flag);
                    end
                end
            end

            DONE: begin
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg         <= 3'd0;
            len_reg         <= 3'd0;
            addr_reg        <= 32'd0;
            wdata_reg       <= 32'd0;
            rdata_reg       <= 32'd0;
            is_fetch_reg    <= 1'b0;
            flushed_reg     <= 1'b0;
            dslot_valid_reg <= 1'b0;
            dslot_store_reg <= 1'b0;
            dslot_len_reg   <= 3'd0;
            dslot_addr_reg  <= 32'd0;
            dslot_data_reg  <= 32'd0;
            fslot_valid_reg <= 1'b0;
            fslot_addr_reg  <= 32'd0;
            data_ok_reg     <= 1'b0;
            data_ans_reg    <= 32'd0;
            if_ok_reg       <= 1'b0;
            if_data_reg     <= 32'd0;
        end else if (rdy) begin
            cnt_reg         <= cnt_next;
            len_reg         <= len_next;
            addr_reg        <= addr_next;
            wdata_reg       <= wdata_next;
            rdata_reg       <= rdata_next;
            is_fetch_reg    <= is_fetch_next;
            flushed_reg     <= flushed_next;
            dslot_valid_reg <= dslot_valid_next;
            dslot_store_reg <= dslot_store_next;
            dslot_len_reg   <= dslot_len_next;
            dslot_addr_reg  <= dslot_addr_next;
            dslot_data_reg  <= dslot_data_next;
            fslot_valid_reg <= fslot_valid_next;
            fslot_addr_reg  <= fslot_addr_next;
            data_ok_reg     <= data_ok_next;
            data_ans_reg    <= data_ans_next;
            if_ok_reg       <= if_ok_next;
            if_data_reg     <= if_data_next;
        end
    end

    assign memctrl_data_ok  = data_ok_reg;
    assign memctrl_data_ans = data_ans_reg;
    assign if_data_ok       = if_ok_reg;
    assign if_data          = if_data_reg;

endmodule

// File: tb/tb_mem_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mem_ctrl
//
// Self-checking bench for mem_ctrl: byte RAM model on the bus, a table of
// single transactions with fixed expected data and latency, and hand-written
// sequences for arbitration, IO stalls, flushes, rdy freeze and reset.
// Completions are checked by a monitor against expectation queues.
// -----------------------------------------------------------------------------
module tb_mem_ctrl;

    localparam logic [5:0] T_LB  = 6'd10;
    localparam logic [5:0] T_LH  = 6'd11;
    localparam logic [5:0] T_LW  = 6'd12;
    localparam logic [5:0] T_LBU = 6'd13;
    localparam logic [5:0] T_LHU = 6'd14;
    localparam logic [5:0] T_SB  = 6'd15;
    localparam logic [5:0] T_SH  = 6'd16;
    localparam logic [5:0] T_SW  = 6'd17;

    localparam int K_LD = 0;
    localparam int K_ST = 1;
    localparam int K_IF = 2;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        rdy;
    logic        Clear_flag;
    logic        SLB_to_memctrl_needchange;
    logic        SLB_to_memctrl_needchange2;
    logic [5:0]  SLB_to_memctrl_ordertype;
    logic [31:0] SLB_to_memctrl_vj;
    logic [31:0] SLB_to_memctrl_A;
    logic [31:0] SLB_to_memctrl_vk;
    logic        memctrl_data_ok;
    logic [31:0] memctrl_data_ans;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_data_ok;
    logic [31:0] if_data;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        io_buffer_full;

    mem_ctrl dut (
        .clk                        (clk),
        .rst                        (rst),
        .rdy                        (rdy),
        .Clear_flag                 (Clear_flag),
        .SLB_to_memctrl_needchange  (SLB_to_memctrl_needchange),
        .SLB_to_memctrl_needchange2 (SLB_to_memctrl_needchange2),
        .SLB_to_memctrl_ordertype   (SLB_to_memctrl_ordertype),
        .SLB_to_memctrl_vj          (SLB_to_memctrl_vj),
        .SLB_to_memctrl_A           (SLB_to_memctrl_A),
        .SLB_to_memctrl_vk          (SLB_to_memctrl_vk),
        .memctrl_data_ok            (memctrl_data_ok),
        .memctrl_data_ans           (memctrl_data_ans),
        .if_req                     (if_req),
        .if_addr                    (if_addr),
        .if_data_ok                 (if_data_ok),
        .if_data                    (if_data),
        .mem_din                    (mem_din),
        .mem_dout                   (mem_dout),
        .mem_a                      (mem_a),
        .mem_wr                     (mem_wr),
        .io_buffer_full             (io_buffer_full)
    );

    // RAM model: 4 KiB, one-cycle read latency; IO addresses are not stored.
    logic [7:0] ram [0:4095];
    int         cyc = 0;

    always @(posedge clk) begin
        if (cyc == 0) begin
            for (int i = 0; i < 4096; i++) ram[i] <= 8'h00;
            ram[12'h000] <= 8'h93;
            ram[12'h001] <= 8'h01;
            ram[12'h002] <= 8'h50;
            ram[12'h003] <= 8'h00;
            ram[12'h100] <= 8'h11;
            ram[12'h101] <= 8'h22;
            ram[12'h102] <= 8'h33;
            ram[12'h103] <= 8'h44;
            ram[12'h104] <= 8'h80;
            ram[12'h105] <= 8'hF0;
        end else if (mem_wr && mem_a < 32'h1000) begin
            ram[mem_a[11:0]] <= mem_dout;
        end
        mem_din <= ram[mem_a[11:0]];
        cyc     <= cyc + 1;
    end

    typedef struct {
        string       name;
        logic [31:0] data;
        int          lo;
        int          hi;
    } exp_t;

    typedef struct {
        string       name;
        int          kind;
        logic [5:0]  t;
        logic [31:0] vj;
        logic [31:0] a;
        logic [31:0] vk;
        logic [31:0] exp_data;
        int          lat;
    } vec_t;

    exp_t dq[$];
    exp_t fq[$];
    vec_t vecs[$];

    int checks   = 0;
    int errors   = 0;
    int d_ok_cnt = 0;
    int i_ok_cnt = 0;

    function automatic vec_t mk(input string name, input int kind, input logic [5:0] t,
                                input logic [31:0] vj, input logic [31:0] a,
                                input logic [31:0] vk, input logic [31:0] exp_data,
                                input int lat);
        vec_t v;
        v.name = name; v.kind = kind; v.t = t; v.vj = vj; v.a = a; v.vk = vk;
        v.exp_data = exp_data; v.lat = lat;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%08h, required 0x%08h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic push_d(input string name, input logic [31:0] d, input int lo, input int hi);
        exp_t e;
        e.name = name; e.data = d; e.lo = lo; e.hi = hi;
        dq.push_back(e);
    endtask

    task automatic push_f(input string name, input logic [31:0] d, input int lo, input int hi);
        exp_t e;
        e.name = name; e.data = d; e.lo = lo; e.hi = hi;
        fq.push_back(e);
    endtask

    // Called once per cycle at the falling edge.
    task automatic mon_step();
        exp_t e;
        if (memctrl_data_ok) begin
            d_ok_cnt++;
            checks++;
            if (dq.size() == 0) begin
                errors++;
                $display("FAIL data_ok_unexpected: pulse at cycle %0d data 0x%08h, required no pulse",
                         cyc, memctrl_data_ans);
            end else begin
                e = dq.pop_front();
                if (memctrl_data_ans !== e.data || cyc < e.lo || cyc > e.hi) begin
                    errors++;
                    $display("FAIL %s: data 0x%08h at cycle %0d, required 0x%08h in cycles %0d..%0d",
                             e.name, memctrl_data_ans, cyc, e.data, e.lo, e.hi);
                end else begin
                    $display("pass %s: data 0x%08h at cycle %0d", e.name, memctrl_data_ans, cyc);
                end
            end
        end else begin
            chk("data_ans_idle_zero", memctrl_data_ans, 32'd0);
        end
        if (if_data_ok) begin
            i_ok_cnt++;
            checks++;
            if (fq.size() == 0) begin
                errors++;
                $display("FAIL if_ok_unexpected: pulse at cycle %0d data 0x%08h, required no pulse",
                         cyc, if_data);
            end else begin
                e = fq.pop_front();
                if (if_data !== e.data || cyc < e.lo || cyc > e.hi) begin
                    errors++;
                    $display("FAIL %s: data 0x%08h at cycle %0d, required 0x%08h in cycles %0d..%0d",
                             e.name, if_data, cyc, e.data, e.lo, e.hi);
                end else begin
                    $display("pass %s: data 0x%08h at cycle %0d", e.name, if_data, cyc);
                end
            end
        end else begin
            chk("if_data_idle_zero", if_data, 32'd0);
        end
    endtask

    // Advance to just after the next rising edge and drop one-cycle pulses.
    task automatic tick();
        @(posedge clk);
        #1;
        SLB_to_memctrl_needchange  = 1'b0;
        SLB_to_memctrl_needchange2 = 1'b0;
        if_req                     = 1'b0;
        Clear_flag                 = 1'b0;
    endtask

    // Start a new cycle and present one request pulse in it; returns c0.
    task automatic send(input int kind, input logic [5:0] t, input logic [31:0] vj,
                        input logic [31:0] a, input logic [31:0] vk, output int c0);
        tick();
        SLB_to_memctrl_ordertype = t;
        SLB_to_memctrl_vj        = vj;
        SLB_to_memctrl_A         = a;
        SLB_to_memctrl_vk        = vk;
        if (kind == K_LD) SLB_to_memctrl_needchange = 1'b1;
        else if (kind == K_ST) SLB_to_memctrl_needchange2 = 1'b1;
        else begin
            if_req  = 1'b1;
            if_addr = vj;
        end
        c0 = cyc;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while ((dq.size() != 0 || fq.size() != 0) && n < budget) begin
            tick();
            n++;
        end
        if (dq.size() != 0 || fq.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL timeout: %0d data and %0d fetch completions outstanding, required 0",
                     dq.size(), fq.size());
            dq.delete();
            fq.delete();
        end
    endtask

    initial begin
        int   c0;
        int   d_before;
        int   i_before;
        vec_t v;

        rst = 1'b1; rdy = 1'b1; Clear_flag = 1'b0; io_buffer_full = 1'b0;
        SLB_to_memctrl_needchange = 1'b0; SLB_to_memctrl_needchange2 = 1'b0;
        SLB_to_memctrl_ordertype = '0; SLB_to_memctrl_vj = '0; SLB_to_memctrl_A = '0;
        SLB_to_memctrl_vk = '0; if_req = 1'b0; if_addr = '0;

        fork
            forever begin
                @(negedge clk);
                mon_step();
            end
        join_none

        repeat (3) tick();
        @(negedge clk);
        chk("reset_mem_a", mem_a, 32'd0);
        chk("reset_mem_wr", {31'd0, mem_wr}, 32'd0);
        chk("reset_mem_dout", {24'd0, mem_dout}, 32'd0);
        chk("reset_data_ok", {31'd0, memctrl_data_ok}, 32'd0);
        chk("reset_if_ok", {31'd0, if_data_ok}, 32'd0);
        tick();
        rst = 1'b0;
        tick();

        vecs.push_back(mk("LW_0x100",      K_LD, T_LW,  32'h0000_00F0, 32'h10,        0, 32'h4433_2211, 6));
        vecs.push_back(mk("LBU_0x102",     K_LD, T_LBU, 32'h0000_0102, 32'h0,        0, 32'h0000_0033, 3));
        vecs.push_back(mk("LH_0x101",      K_LD, T_LH,  32'h0000_0100, 32'h1,        0, 32'h0000_3322, 4));
        vecs.push_back(mk("LB_neg_off",    K_LD, T_LB,  32'h0000_0104, 32'hFFFF_FFFF, 0, 32'h0000_0044, 3));
        vecs.push_back(mk("LHU_0x102",     K_LD, T_LHU, 32'h0000_0102, 32'h0,        0, 32'h0000_4433, 4));
        vecs.push_back(mk("LB_raw_0x80",   K_LD, T_LB,  32'h0000_0104, 32'h0,        0, 32'h0000_0080, 3));
        vecs.push_back(mk("LH_raw_0xF080", K_LD, T_LH,  32'h0000_0104, 32'h0,        0, 32'h0000_F080, 4));
        vecs.push_back(mk("LW_wrap_addr",  K_LD, T_LW,  32'hFFFF_FF00, 32'h200,      0, 32'h4433_2211, 6));
        vecs.push_back(mk("SW_0x200",      K_ST, T_SW,  32'h0000_0200, 32'h0, 32'hDEAD_BEEF, 32'h0, 5));
        vecs.push_back(mk("LW_0x200",      K_LD, T_LW,  32'h0000_0200, 32'h0,        0, 32'hDEAD_BEEF, 6));
        vecs.push_back(mk("SB_0x204",      K_ST, T_SB,  32'h0000_0204, 32'h0, 32'h1234_56AB, 32'h0, 2));
        vecs.push_back(mk("SH_0x206",      K_ST, T_SH,  32'h0000_0200, 32'h6, 32'h9876_CAFE, 32'h0, 3));
        vecs.push_back(mk("LW_0x204",      K_LD, T_LW,  32'h0000_0204, 32'h0,        0, 32'hCAFE_00AB, 6));
        vecs.push_back(mk("IF_0x100",      K_IF, 6'd0,  32'h0000_0100, 32'h0,        0, 32'h4433_2211, 6));
        vecs.push_back(mk("IF_0x000",      K_IF, 6'd0,  32'h0000_0000, 32'h0,        0, 32'h0050_0193, 6));

        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            send(v.kind, v.t, v.vj, v.a, v.vk, c0);
            if (v.kind == K_IF) push_f(v.name, v.exp_data, c0 + v.lat, c0 + v.lat);
            else push_d(v.name, v.exp_data, c0 + v.lat, c0 + v.lat);
            wait_done(40);
        end

        // Address sequence of a word load, with the bus idle in c0.
        send(K_LD, T_LW, 32'h100, 32'h0, 32'h0, c0);
        push_d("LW_seq", 32'h4433_2211, c0 + 6, c0 + 6);
        @(negedge clk);
        chk("LW_seq_c0_idle_a", mem_a, 32'd0);
        for (int k = 0; k < 4; k++) begin
            tick();
            @(negedge clk);
            chk("LW_seq_mem_a", mem_a, 32'h100 + k);
            chk("LW_seq_mem_wr", {31'd0, mem_wr}, 32'd0);
        end
        wait_done(40);

        // Load and fetch in the same cycle: load first, fetch after a bubble.
        send(K_LD, T_LW, 32'h100, 32'h0, 32'h0, c0);
        if_req  = 1'b1;
        if_addr = 32'h0;
        push_d("arb_load", 32'h4433_2211, c0 + 6, c0 + 6);
        push_f("arb_fetch", 32'h0050_0193, c0 + 12, c0 + 14);
        wait_done(40);

        // SB to IO with the buffer full for three cycles.
        send(K_ST, T_SB, 32'h0003_0000, 32'h0, 32'h0000_005A, c0);
        io_buffer_full = 1'b1;
        push_d("SB_io_stall", 32'h0, c0 + 5, c0 + 5);
        for (int k = 1; k <= 3; k++) begin
            tick();
            @(negedge clk);
            chk("io_stall_mem_a", mem_a, 32'h0003_0000);
            chk("io_stall_mem_wr", {31'd0, mem_wr}, 32'd0);
        end
        tick();
        io_buffer_full = 1'b0;
        @(negedge clk);
        chk("io_write_mem_wr", {31'd0, mem_wr}, 32'd1);
        chk("io_write_mem_dout", {24'd0, mem_dout}, 32'h5A);
        wait_done(40);

        // Flush in the middle of a load: no completion, bus idle next cycle.
        d_before = d_ok_cnt;
        send(K_LD, T_LW, 32'h100, 32'h0, 32'h0, c0);
        tick();
        tick();
        Clear_flag = 1'b1;
        tick();
        @(negedge clk);
        chk("clr_ld_mem_a", mem_a, 32'd0);
        chk("clr_ld_mem_wr", {31'd0, mem_wr}, 32'd0);
        repeat (10) tick();
        chk("clr_ld_no_ok", d_ok_cnt - d_before, 32'd0);

        // Flush mid-store with a same-cycle fetch: store completes silently,
        // the fetch is ignored.
        d_before = d_ok_cnt;
        i_before = i_ok_cnt;
        send(K_ST, T_SW, 32'h300, 32'h0, 32'h1122_3344, c0);
        tick();
        tick();
        Clear_flag = 1'b1;
        if_req     = 1'b1;
        if_addr    = 32'h0;
        repeat (12) tick();
        chk("clr_st_no_ok", d_ok_cnt - d_before, 32'd0);
        chk("clr_same_cycle_req", i_ok_cnt - i_before, 32'd0);
        send(K_LD, T_LW, 32'h300, 32'h0, 32'h0, c0);
        push_d("LW_after_clr_st", 32'h1122_3344, c0 + 6, c0 + 6);
        wait_done(40);

        // rdy low for three cycles stretches a byte load; a fetch pulse
        // presented while frozen is dropped.
        i_before = i_ok_cnt;
        send(K_LD, T_LB, 32'h103, 32'h0, 32'h0, c0);
        push_d("LB_rdy_freeze", 32'h0000_0044, c0 + 6, c0 + 6);
        tick();
        rdy = 1'b0;
        tick();
        if_req  = 1'b1;
        if_addr = 32'h100;
        tick();
        tick();
        rdy = 1'b1;
        wait_done(40);
        repeat (10) tick();
        chk("rdy_drop_pulse", i_ok_cnt - i_before, 32'd0);

        // Reset in the middle of a store.
        d_before = d_ok_cnt;
        send(K_ST, T_SW, 32'h340, 32'h0, 32'hDEAD_BEEF, c0);
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_mem_a", mem_a, 32'd0);
        chk("rst_mid_mem_wr", {31'd0, mem_wr}, 32'd0);
        chk("rst_mid_mem_dout", {24'd0, mem_dout}, 32'd0);
        repeat (10) tick();
        chk("rst_mid_no_ok", d_ok_cnt - d_before, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
